// File: rtl/prog_loader_if.sv
// Bundle between the program loader and its surroundings: the incoming word
// stream plus the shared byte-write port of the instruction and data memories.
interface prog_loader_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 12
);
   logic              s_valid;
   logic              s_ready;
   logic [XLEN-1:0]   s_data;
   logic              im_we;
   logic              dm_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_byte;

   // The loader sinks the stream and drives the memory write port.
   modport slave (
      input  s_valid,
      input  s_data,
      output s_ready,
      output im_we,
      output dm_we,
      output mem_addr,
      output mem_byte
   );

   modport master (
      output s_valid,
      output s_data,
      input  s_ready,
      input  im_we,
      input  dm_we,
      input  mem_addr,
      input  mem_byte
   );
endinterface

// File: rtl/prog_loader.sv
// Streams XLEN-bit words into instruction or data memory as little-endian byte
// writes, holding the core in reset until a load has finished.
module prog_loader #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 12,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              target_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [CNT_W-1:0]  word_count_i,
   prog_loader_if.slave      bus,
   output logic              busy_o,
   output logic              done_o,
   output logic              cpu_reset_n_o
);

   localparam int BYTES  = XLEN / 8;
   localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES - 1);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      WRITE,
      DONE
   } state_t;

   state_t            state_q;
   logic              target_q;
   logic [ADDR_W-1:0] ptr_q;
   logic [CNT_W-1:0]  wordsLeft_q;
   logic [XLEN-1:0]   shift_q;
   logic [BIDX_W-1:0] byteIdx_q;
   logic              imWe_q;
   logic              dmWe_q;
   logic [ADDR_W-1:0] memAddr_q;
   logic [7:0]        memByte_q;
   logic              busy_q;
   logic              done_q;
   logic              cpuResetN_q;
   logic              loaded_q;
   logic              sReady;

   assign sReady = (state_q == FETCH);

   // loaded_q remembers that at least one load finished since reset, so the
   // core is only released once a real program is in place.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         target_q    <= 1'b0;
         ptr_q       <= '0;
         wordsLeft_q <= '0;
         shift_q     <= '0;
         byteIdx_q   <= '0;
         imWe_q      <= 1'b0;
         dmWe_q      <= 1'b0;
         memAddr_q   <= '0;
         memByte_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cpuResetN_q <= 1'b0;
         loaded_q    <= 1'b0;
      end else begin
         imWe_q <= 1'b0;
         dmWe_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  target_q    <= target_i;
                  ptr_q       <= base_addr_i;
                  wordsLeft_q <= word_count_i;
                  cpuResetN_q <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= (word_count_i == '0) ? DONE : FETCH;
               end else if (loaded_q) begin
                  cpuResetN_q <= 1'b1;
               end
            end
            FETCH: begin
               if (bus.s_valid && sReady) begin
                  shift_q   <= bus.s_data;
                  byteIdx_q <= '0;
                  state_q   <= WRITE;
               end
            end
            WRITE: begin
               imWe_q    <= ~target_q;
               dmWe_q    <= target_q;
               memAddr_q <= ptr_q;
               memByte_q <= shift_q[7:0];
               shift_q   <= shift_q >> 8;
               ptr_q     <= ptr_q + ADDR_W'(1);
               byteIdx_q <= byteIdx_q + BIDX_W'(1);
               if (byteIdx_q == LAST_BYTE) begin
                  wordsLeft_q <= wordsLeft_q - CNT_W'(1);
                  state_q     <= (wordsLeft_q == CNT_W'(1)) ? DONE : FETCH;
               end
            end
            DONE: begin
               done_q   <= 1'b1;
               loaded_q <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.s_ready   = sReady;
   assign bus.im_we     = imWe_q;
   assign bus.dm_we     = dmWe_q;
   assign bus.mem_addr  = memAddr_q;
   assign bus.mem_byte  = memByte_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign cpu_reset_n_o = cpuResetN_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: each load is planned as a per-cycle
// timeline of inputs and expected outputs, then compared on every falling edge.
module tb_prog_loader;

   localparam int XLEN   = 32;
   localparam int ADDR_W = 12;
   localparam int CNT_W  = 16;
   localparam int BYTES  = XLEN / 8;
   localparam int MAXC   = 4000;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              target = 1'b0;
   logic [ADDR_W-1:0] base = '0;
   logic [CNT_W-1:0]  count = '0;
   logic              busy;
   logic              done;
   logic              cpuResetN;

   prog_loader_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

   prog_loader #(.XLEN(XLEN), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .start_i       (start),
      .target_i      (target),
      .base_addr_i   (base),
      .word_count_i  (count),
      .bus           (bus),
      .busy_o        (busy),
      .done_o        (done),
      .cpu_reset_n_o (cpuResetN)
   );

   always #5 clk = ~clk;

   // Per-cycle expected outputs (index = number of rising edges so far).
   bit              expReady [MAXC];
   bit              expIm    [MAXC];
   bit              expDm    [MAXC];
   bit              expDone  [MAXC];
   bit              expBusy  [MAXC];
   bit              expCpu   [MAXC];
   bit [ADDR_W-1:0] expAddr  [MAXC];
   bit [7:0]        expByte  [MAXC];

   // Per-cycle inputs, driven on the falling edge of that cycle.
   bit              inStart  [MAXC];
   bit              inTarget [MAXC];
   bit [ADDR_W-1:0] inBase   [MAXC];
   bit [CNT_W-1:0]  inCount  [MAXC];
   bit              inValid  [MAXC];
   bit [XLEN-1:0]   inData   [MAXC];

   bit [XLEN-1:0] words  [64];
   int            delays [64];

   typedef struct {
      bit              dm;
      bit [ADDR_W-1:0] addr;
      bit [7:0]        data;
   } wr_t;

   wr_t wrLog[$];
   int  cyc = 0;
   int  checks = 0;
   int  errors = 0;
   int  readyCnt = 0;
   int  lastDoneCyc = -1;
   int  cpuRiseCyc = -1;
   bit  prevCpu = 1'b0;

   always @(posedge clk) cyc++;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   // Compare the DUT against the planned timeline, then drive this cycle's inputs.
   always @(negedge clk) begin
      if (rst_n && cyc < MAXC) begin
         checkOutput("s_ready", bus.s_ready, expReady[cyc]);
         checkOutput("im_we", bus.im_we, expIm[cyc]);
         checkOutput("dm_we", bus.dm_we, expDm[cyc]);
         checkOutput("done", done, expDone[cyc]);
         checkOutput("busy", busy, expBusy[cyc]);
         checkOutput("cpu_reset_n", cpuResetN, expCpu[cyc]);
         if (expIm[cyc] || expDm[cyc]) begin
            checkOutput("mem_addr", bus.mem_addr, expAddr[cyc]);
            checkOutput("mem_byte", bus.mem_byte, expByte[cyc]);
         end
         if (bus.im_we === 1'b1 || bus.dm_we === 1'b1)
            wrLog.push_back('{dm: bus.dm_we, addr: bus.mem_addr, data: bus.mem_byte});
         if (bus.s_ready === 1'b1) readyCnt++;
         if (done === 1'b1) lastDoneCyc = cyc;
         if (cpuResetN === 1'b1 && !prevCpu) cpuRiseCyc = cyc;
         prevCpu = (cpuResetN === 1'b1);
      end else begin
         prevCpu = 1'b0;
      end
      if (cyc < MAXC) begin
         start       = inStart[cyc];
         target      = inTarget[cyc];
         base        = inBase[cyc];
         count       = inCount[cyc];
         bus.s_valid = inValid[cyc];
         bus.s_data  = inData[cyc];
      end
   end

   // Timeline of one load with start driven in cycle s: word k's fetch window
   // opens at f, the word is offered after delays[k] cycles, its BYTES writes
   // become visible two cycles after it is offered, and the next window opens
   // 1+BYTES cycles after the offer. Returns the cycle the loader sits in DONE.
   function automatic int planLoad(int s, bit tgt, int b, int n, bit eager, bit busyStart);
      int f;
      int a;
      int prevA;
      int d;
      int c;
      inStart[s]  = 1'b1;
      inTarget[s] = tgt;
      inBase[s]   = ADDR_W'(b);
      inCount[s]  = CNT_W'(n);
      f = s + 1;
      prevA = -1;
      for (int k = 0; k < n; k++) begin
         a = f + delays[k];
         for (int x = f; x <= a; x++) begin
            expReady[x] = 1'b1;
            inData[x]   = $urandom;
         end
         if (eager && k > 0 && delays[k] == 0) begin
            for (int x = prevA + 1; x <= a; x++) begin
               inValid[x] = 1'b1;
               inData[x]  = words[k];
            end
         end
         inValid[a] = 1'b1;
         inData[a]  = words[k];
         for (int j = 0; j < BYTES; j++) begin
            c = a + 2 + j;
            expIm[c]   = ~tgt;
            expDm[c]   = tgt;
            expAddr[c] = ADDR_W'(b + k * BYTES + j);
            expByte[c] = 8'(words[k] >> (8 * j));
         end
         prevA = a;
         f = a + 1 + BYTES;
      end
      d = f;
      for (int x = s + 1; x <= d; x++) begin
         expBusy[x]  = 1'b1;
         inTarget[x] = 1'($urandom_range(0, 1));
         inBase[x]   = ADDR_W'($urandom);
         inCount[x]  = CNT_W'($urandom);
      end
      if (busyStart) inStart[$urandom_range(s + 1, d)] = 1'b1;
      expDone[d + 1] = 1'b1;
      for (int x = s + 1; x <= d + 1; x++) expCpu[x] = 1'b0;
      for (int x = d + 2; x < MAXC; x++) expCpu[x] = 1'b1;
      return d;
   endfunction

   task automatic applyStimulus(input int s, input bit tgt, input int b, input int n,
                                input bit eager, input bit busyStart, output int d);
      wrLog.delete();
      readyCnt    = 0;
      lastDoneCyc = -1;
      cpuRiseCyc  = -1;
      d = planLoad(s, tgt, b, n, eager, busyStart);
   endtask

   task automatic runUntil(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic clearFrom(input int c);
      for (int x = c; x < MAXC; x++) begin
         expReady[x] = 0; expIm[x] = 0; expDm[x] = 0; expDone[x] = 0;
         expBusy[x] = 0; expCpu[x] = 0; inStart[x] = 0; inValid[x] = 0;
      end
   endtask

   task automatic checkIdleZero(input string tag);
      checkOutput({tag, " s_ready"}, bus.s_ready, 0);
      checkOutput({tag, " we"}, {bus.im_we, bus.dm_we}, 0);
      checkOutput({tag, " mem_addr"}, bus.mem_addr, 0);
      checkOutput({tag, " mem_byte"}, bus.mem_byte, 0);
      checkOutput({tag, " busy"}, busy, 0);
      checkOutput({tag, " done"}, done, 0);
      checkOutput({tag, " cpu_reset_n"}, cpuResetN, 0);
   endtask

   initial begin
      #(MAXC * 10 + 100);
      $display("[TB] FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int s;
      int d;
      bit [7:0] instBytes [8];
      instBytes = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
      bus.s_valid = 1'b0;
      bus.s_data  = '0;

      #1 checkIdleZero("reset");
      @(negedge clk); @(negedge clk);
      #1 rst_n = 1'b1;

      // Instruction load of two words.
      $display("[TB] instruction load");
      s = cyc + 2;
      words[0] = 32'h00500093; words[1] = 32'h00A00113;
      delays[0] = 0; delays[1] = 0;
      applyStimulus(s, 1'b0, 0, 2, 1'b0, 1'b0, d);
      runUntil(d + 4);
      checkOutput("inst log size", wrLog.size(), 8);
      for (int i = 0; i < 8 && i < wrLog.size(); i++) begin
         checkOutput("inst byte", wrLog[i].data, instBytes[i]);
         checkOutput("inst addr", wrLog[i].addr, i);
         checkOutput("inst dm", wrLog[i].dm, 0);
      end
      checkOutput("inst latency", lastDoneCyc - s, 12);
      checkOutput("inst cpu rise", cpuRiseCyc - lastDoneCyc, 1);

      // Data load of one negative word.
      $display("[TB] data load");
      s = cyc + 2;
      words[0] = 32'hFFFFFFF8; delays[0] = 1;
      applyStimulus(s, 1'b1, 0, 1, 1'b0, 1'b0, d);
      runUntil(d + 3);
      checkOutput("data log size", wrLog.size(), 4);
      for (int i = 0; i < 4 && i < wrLog.size(); i++) begin
         checkOutput("data byte", wrLog[i].data, (i == 0) ? 8'hF8 : 8'hFF);
         checkOutput("data dm", wrLog[i].dm, 1);
      end

      // Zero-length load.
      $display("[TB] zero count");
      s = cyc + 2;
      applyStimulus(s, 1'b0, 5, 0, 1'b0, 1'b0, d);
      runUntil(d + 3);
      checkOutput("zero done latency", lastDoneCyc - s, 2);
      checkOutput("zero writes", wrLog.size(), 0);
      checkOutput("zero ready", readyCnt, 0);

      // Address wrap with a stalled source.
      $display("[TB] wrap and backpressure");
      s = cyc + 2;
      words[0] = 32'hDEADBEEF; delays[0] = 5;
      applyStimulus(s, 1'b1, 12'hFFE, 1, 1'b0, 1'b0, d);
      runUntil(d + 3);
      checkOutput("wrap ready cycles", readyCnt, 6);
      checkOutput("wrap log size", wrLog.size(), 4);
      if (wrLog.size() == 4) begin
         checkOutput("wrap addr0", wrLog[0].addr, 12'hFFE);
         checkOutput("wrap addr1", wrLog[1].addr, 12'hFFF);
         checkOutput("wrap addr2", wrLog[2].addr, 12'h000);
         checkOutput("wrap addr3", wrLog[3].addr, 12'h001);
         checkOutput("wrap byte0", wrLog[0].data, 8'hEF);
      end

      // Start pulsed while busy must be ignored.
      $display("[TB] busy start");
      s = cyc + 2;
      for (int k = 0; k < 3; k++) begin words[k] = $urandom; delays[k] = k; end
      applyStimulus(s, 1'b0, 12'h100, 3, 1'b0, 1'b1, d);
      runUntil(d + 3);
      checkOutput("busy log size", wrLog.size(), 12);
      for (int i = 0; i < wrLog.size(); i++)
         checkOutput("busy addr", wrLog[i].addr, 12'h100 + i);

      // Randomised loads, some back to back.
      $display("[TB] random loads");
      s = cyc + 2;
      for (int t = 0; t < 24; t++) begin
         int n;
         n = $urandom_range(0, 6);
         for (int k = 0; k < n; k++) begin
            words[k]  = $urandom;
            delays[k] = $urandom_range(0, 3);
         end
         applyStimulus(s, 1'($urandom_range(0, 1)), $urandom_range(0, 4095), n,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d);
         if ($urandom_range(0, 1) == 1) begin
            runUntil(d);
            s = d + 1;
         end else begin
            runUntil(d + 2);
            s = cyc + 2 + $urandom_range(0, 3);
         end
      end
      runUntil(d + 4);

      // Reset during the third byte of the first word.
      $display("[TB] reset mid-load");
      s = cyc + 2;
      words[0] = 32'h11223344; words[1] = 32'h55667788;
      delays[0] = 0; delays[1] = 0;
      applyStimulus(s, 1'b1, 12'h040, 2, 1'b0, 1'b0, d);
      runUntil(s + 4);
      @(posedge clk);
      #2 rst_n = 1'b0;
      clearFrom(cyc);
      #1 checkIdleZero("async reset");
      @(negedge clk);
      #1 rst_n = 1'b1;
      runUntil(cyc + 3);
      s = cyc + 2;
      words[0] = 32'hA5A5A5A5; delays[0] = 0;
      applyStimulus(s, 1'b0, 12'h080, 1, 1'b0, 1'b0, d);
      runUntil(d + 4);
      checkOutput("post-reset log size", wrLog.size(), 4);
      if (wrLog.size() == 4) checkOutput("post-reset addr0", wrLog[0].addr, 12'h080);
      checkOutput("post-reset cpu rise", cpuRiseCyc - lastDoneCyc, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Hardware program/data loader for the RV32I core.
- Accepts a valid/ready word stream and splits each word into little-endian byte writes on the byte-addressed instruction or data memory port (Mem[i] = data[7:0], Mem[i+1] = data[15:8], ...).
- Holds the core in reset until a load has completed, replacing file-based memory preloading.
- Generalised in word width, address width and load length, with runtime base address and target select.

Parameters:
- XLEN, 32, stream word width in bits; must be a multiple of 8. BYTES = XLEN/8.
- ADDR_W, 12, byte address width of the memory ports.
- CNT_W, 16, width of the word count.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  begin a load; sampled only in IDLE
- target  input  1  0 = instruction memory, 1 = data memory; latched at start
- base_addr  input  ADDR_W  first byte address; latched at start
- word_count  input  CNT_W  number of XLEN words to load; latched at start
- s_valid  input  1  stream word valid
- s_ready  output  1  loader can accept a word
- s_data  input  XLEN  stream word
- im_we  output  1  instruction memory byte write enable
- dm_we  output  1  data memory byte write enable
- mem_addr  output  ADDR_W  byte address, shared by both memories
- mem_byte  output  8  byte write data
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse at the end of a load
- cpu_reset_n  output  1  active-low reset to the core

Behaviour:
- Reset (reset = 0, asynchronous) forces the following, from any state including mid-load. No partial-word completion.
  - state = IDLE
  - s_ready = im_we = dm_we = done = busy = 0
  - mem_addr = 0, mem_byte = 0
  - cpu_reset_n = 0
  - internal pointer, counter and shift register = 0
- All outputs are registered except s_ready, which is decoded from state (high only in FETCH).
- IDLE:
  - On start = 1, latch target, base_addr and word_count.
  - If word_count == 0, go to DONE; otherwise go to FETCH.
  - cpu_reset_n drops to 0 on the cycle after the start edge.
- FETCH:
  - s_ready = 1.
  - On s_valid & s_ready, capture s_data into the shift register, clear byte_idx and go to WRITE.
  - While s_valid = 0, stay in FETCH with no writes.
- WRITE (BYTES cycles per word):
  - Each cycle assert exactly one of im_we / dm_we (per latched target).
  - mem_addr = ptr; mem_byte = shift register [7:0].
  - Then shift right by 8, ptr = ptr + 1, byte_idx = byte_idx + 1.
  - After byte BYTES-1, decrement words_left. If it reaches 0, go to DONE; otherwise go to FETCH.
- DONE:
  - done = 1 for exactly one cycle, we = 0, then return to IDLE.
  - cpu_reset_n goes to 1 on the cycle after the done pulse.
- cpu_reset_n:
  - 0 from reset until the first completed load.
  - 0 during any subsequent load (not IDLE).
  - 1 otherwise.
- Throughput: 1 + BYTES cycles per word with s_valid held high.
  - Load latency = 1 + N*(1 + BYTES) + 1 cycles from the start edge to the done pulse.
- ptr is ADDR_W bits and wraps modulo 2^ADDR_W (0xFFF + 1 -> 0x000). The wrap is silent; no error flag.
- start while busy is ignored; latched parameters are not disturbed.
- s_valid during WRITE or DONE is not accepted (s_ready = 0); the source must hold the word.
- Back-to-back loads: start asserted in the cycle IDLE is re-entered begins a new load. The previous load's data is unaffected.

Test Plan:
- Instruction load:
  - Stimulus: target = 0, base 0x000, count 2, words 0x00500093, 0x00A00113.
  - Response: im_we bytes 93,00,50,00,13,01,A0,00 at addrs 0..7; dm_we never high; done one cycle; cpu_reset_n rises the cycle after done.
- Data load:
  - Stimulus: target = 1, base 0x000, count 1, word 0xFFFFFFF8 (-8).
  - Response: dm_we bytes F8,FF,FF,FF at addrs 0..3; im_we stays 0.
- Zero count:
  - Stimulus: count = 0.
  - Response: done pulse 2 cycles after start; no we asserted; s_ready never high.
- Wrap and backpressure:
  - Stimulus: ADDR_W = 4, base 0xE, count 1, s_valid delayed 5 cycles.
  - Response: s_ready high for all 5 idle cycles; writes go to addrs E,F,0,1.
- Reset mid-load:
  - Stimulus: reset = 0 during the third byte of a word.
  - Response: all outputs zero immediately (asynchronous); state IDLE after release; cpu_reset_n stays 0 until a fresh load completes.
- Busy start:
  - Stimulus: start pulsed with a different base during FETCH.
  - Response: ignored; addresses continue from the original base.
